fp_divider: RTL

//  Iterative floating-point divider for the 24-bit {sign, exp[6:0], frac[15:0]} format, exponent bias 63,

---
 rtl/fp_divider_if.sv | 25 ++
 rtl/fp_divider.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for fp_divider: {sign, exp, frac} words
// travel with valid/ready on both the input and the output side.
interface fp_divider_if #(
  parameter int W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_underflow;
  logic         out_overflow;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_underflow, out_overflow
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_underflow, out_overflow
  );
endinterface

// File: rtl/fp_divider.sv
// Restoring floating-point divider, one quotient bit per cycle then normalise.
// Define FP_DIV_ROUND_EN for an extra guard iteration and round-half-up.
module fp_divider #(
  parameter int EXP_W  = 7,
  parameter int FRAC_W = 16,
  parameter int BIAS   = 63
) (
  input  logic         clk,
  input  logic         rst,
  fp_divider_if.slave  bus
);

  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int MANT_W = FRAC_W + 1;
  localparam int REM_W  = FRAC_W + 2;
`ifdef FP_DIV_ROUND_EN
  localparam int N      = FRAC_W + 3;
`else
  localparam int N      = FRAC_W + 2;
`endif
  localparam int CNT_W  = $clog2(N);
  localparam int E_W    = EXP_W + 3;

  localparam logic signed [E_W-1:0] BIAS_E  = E_W'(BIAS);
  localparam logic signed [E_W-1:0] ONE_E   = E_W'(1);
  localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [REM_W-1:0]        r_rem;
  logic [N-1:0]            r_quot;
  logic [MANT_W-1:0]       r_divisor;
  logic                    r_sign;
  logic signed [E_W-1:0]   r_exp;
  logic                    r_inReady;
  logic                    r_outValid;
  logic [W-1:0]            r_result;
  logic                    r_underflow;
  logic                    r_overflow;

  logic signed [E_W-1:0]   w_expIn;
  logic                    w_ge;
  logic [REM_W-1:0]        w_remSub;
  logic [REM_W-1:0]        w_remNext;
  logic [FRAC_W-1:0]       w_frac;
  logic signed [E_W-1:0]   w_expNorm;
  logic [FRAC_W-1:0]       w_fracRnd;
  logic signed [E_W-1:0]   w_expRnd;
  logic [W-1:0]            w_result;
  logic                    w_underflow;
  logic                    w_overflow;

  assign w_expIn = $signed({{(E_W-EXP_W){1'b0}}, bus.in_a[W-2 -: EXP_W]})
                 - $signed({{(E_W-EXP_W){1'b0}}, bus.in_b[W-2 -: EXP_W]})
                 + BIAS_E;

  // Remainder stays below 2*divisor, so the MSB dropped by the shift is always zero.
  assign w_ge      = (r_rem >= {1'b0, r_divisor});
  assign w_remSub  = w_ge ? (r_rem - {1'b0, r_divisor}) : r_rem;
  assign w_remNext = {w_remSub[REM_W-2:0], 1'b0};

`ifdef FP_DIV_ROUND_EN
  logic              w_guard;
  logic [FRAC_W:0]   w_fracSum;

  always_comb begin
    w_frac    = r_quot[N-2 -: FRAC_W];
    w_expNorm = r_exp;
    w_guard   = r_quot[N-2-FRAC_W];
    if (!r_quot[N-1]) begin
      w_frac    = r_quot[N-3 -: FRAC_W];
      w_expNorm = r_exp - ONE_E;
      w_guard   = r_quot[N-3-FRAC_W];
    end
  end

  // A carry out of the fraction leaves it all-zero and bumps the exponent.
  assign w_fracSum = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_guard};
  assign w_fracRnd = w_fracSum[FRAC_W-1:0];
  assign w_expRnd  = w_expNorm + $signed({{(E_W-1){1'b0}}, w_fracSum[FRAC_W]});
`else
  always_comb begin
    w_frac    = r_quot[N-2 -: FRAC_W];
    w_expNorm = r_exp;
    if (!r_quot[N-1]) begin
      w_frac    = r_quot[N-3 -: FRAC_W];
      w_expNorm = r_exp - ONE_E;
    end
  end

  assign w_fracRnd = w_frac;
  assign w_expRnd  = w_expNorm;
`endif

  always_comb begin
    w_underflow = 1'b0;
    w_overflow  = 1'b0;
    w_result    = {r_sign, w_expRnd[EXP_W-1:0], w_fracRnd};
    if (w_expRnd[E_W-1]) begin
      w_underflow = 1'b1;
      w_result    = {r_sign, {(W-1){1'b0}}};
    end else if (w_expRnd > EXP_MAX) begin
      w_overflow  = 1'b1;
      w_result    = {r_sign, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quot      <= '0;
      r_divisor   <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_inReady   <= 1'b1;
      r_outValid  <= 1'b0;
      r_result    <= '0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_rem     <= {2'b01, bus.in_a[FRAC_W-1:0]};
            r_divisor <= {1'b1, bus.in_b[FRAC_W-1:0]};
            r_quot    <= '0;
            r_cnt     <= '0;
            r_sign    <= bus.in_a[W-1] ^ bus.in_b[W-1];
            r_exp     <= w_expIn;
            r_inReady <= 1'b0;
            r_state   <= DIV;
          end
        end
        DIV: begin
          r_rem  <= w_remNext;
          r_quot <= {r_quot[N-2:0], w_ge};
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N-1))
            r_state <= NORM;
        end
        NORM: begin
          r_result    <= w_result;
          r_underflow <= w_underflow;
          r_overflow  <= w_overflow;
          r_outValid  <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready      = r_inReady;
  assign bus.out_valid     = r_outValid;
  assign bus.out_result    = r_result;
  assign bus.out_underflow = r_underflow;
  assign bus.out_overflow  = r_overflow;

endmodule
